match_ctrl: RTL and testbench
=============================

# match_ctrl

Round and match sequencer for the two-player tug-of-war game. It watches the playfield edge lights and the player button pulses, awards points, and holds the playfield in reset between rounds. It keeps both players' scores and declares the match winner at a target score. It sits between the button-conditioning logic and the playfield and score-display datapath, and is the only block that drives the playfield reset.

## Interface
- WIN_SCORE, 7: points needed to win the match; legal range 1..7.
- HOLD_CYCLES, 4: cycles the playfield is held in reset after each point; legal range 1..255.

- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- L  input  1  left-player press; synchronized, one-cycle pulse.
- R  input  1  right-player press; synchronized, one-cycle pulse.
- ledr9  input  1  leftmost playfield light is lit.
- ledr1  input  1  rightmost playfield light is lit.
- new_match  input  1  one-cycle pulse; restarts the game from MATCH_OVER, ignored in all other states.
- play_reset  output  1  drives the playfield to its center-light state.
- scoreL  output  3  left score, unsigned, 0..WIN_SCORE.
- scoreR  output  3  right score, unsigned, 0..WIN_SCORE.
- point_L  output  1  one-cycle pulse when left scores.
- point_R  output  1  one-cycle pulse when right scores.
- match_over  output  1  high while in MATCH_OVER.
- winner_L  output  1  high in MATCH_OVER if left won.
- winner_R  output  1  high in MATCH_OVER if right won.

## Operation
- States: HOLD, PLAY, MATCH_OVER.
- Reset (reset=0, asynchronous) forces:
  - state=HOLD, hold counter=0;
  - play_reset=1;
  - scoreL=scoreR=0;
  - point_L=point_R=0, match_over=winner_L=winner_R=0.
- HOLD:
  - play_reset=1 and L/R are ignored.
  - The hold counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1, the counter clears and the state goes to PLAY.
- PLAY: play_reset=0. Evaluate in this order:
  - Left point: ledr9 & L & ~R.
  - Right point: ledr1 & R & ~L.
  - If both conditions or neither hold, no point is awarded and the state stays PLAY.
- On a left point:
  - scoreL <= scoreL+1 and point_L pulses for one cycle.
  - If scoreL+1 == WIN_SCORE, go to MATCH_OVER with winner_L=1.
  - Otherwise go to HOLD with the counter at 0.
- Right points mirror left points.
- MATCH_OVER:
  - play_reset=1, match_over=1, and the winner flag holds its value.
  - Scores are frozen and L/R are ignored.
  - new_match=1 clears both scores and both winner flags, deasserts match_over, and goes to HOLD with the counter at 0.
- Scores never exceed WIN_SCORE and never wrap, since reaching WIN_SCORE always exits PLAY.
- At most one of point_L/point_R is high in any cycle, and at most one winner flag is high.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- A point condition true at edge N gives, in the cycle after edge N:
  - the score updated;
  - point_x=1;
  - play_reset=1.
- After a point, play_reset stays high for exactly HOLD_CYCLES cycles; PLAY (play_reset=0) begins at edge N+HOLD_CYCLES.
- From reset release, play_reset is high for HOLD_CYCLES cycles, then the block enters PLAY.
- A winning point gives match_over=1, winner_x=1 and point_x=1 in the same cycle. play_reset stays high until HOLD completes after new_match.
- new_match sampled at edge M gives match_over=0 and scores=0 after edge M; PLAY begins at edge M+HOLD_CYCLES.
- A reset assertion mid-HOLD, mid-PLAY or in MATCH_OVER takes effect immediately, without waiting for clk, and returns all outputs to their reset values.

## Test plan
- Reset release with HOLD_CYCLES=4, then idle inputs -> play_reset=1 for 4 cycles then 0; scores stay 0.
- In PLAY, pulse L with ledr9=1 for one cycle -> next cycle scoreL=1, point_L=1 for one cycle, play_reset=1 for 4 cycles; L pulses during HOLD do not change scoreL.
- In PLAY, ledr9=ledr1=1 with L=R=1 together, then ledr1=1 with L=R=1 -> no point awarded, no pulses, state stays PLAY.
- WIN_SCORE=3, award right three points -> after the third, scoreR=3, match_over=1, winner_R=1, winner_L=0; further L/R with ledr1/ledr9 leave scores at 3.
- In MATCH_OVER, pulse new_match -> next cycle scoreL=scoreR=0, match_over=0, winner_R=0, play_reset=1 for HOLD_CYCLES cycles, then PLAY.
- Drop reset to 0 mid-HOLD with scoreL=2 -> immediately scoreL=0, play_reset=1, all pulse and flag outputs 0.

Source files
------------

// File: rtl/match_ctrl.sv
// Round and match sequencer for the two-player tug-of-war game.
// Awards points, holds the playfield in reset between rounds and declares the match winner.
module match_ctrl #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       ledr9,
    input  logic       ledr1,
    input  logic       new_match,
    output logic       play_reset,
    output logic [2:0] scoreL,
    output logic [2:0] scoreR,
    output logic       point_L,
    output logic       point_R,
    output logic       match_over,
    output logic       winner_L,
    output logic       winner_R
);

    localparam logic [2:0] WinVal   = 3'(WIN_SCORE);
    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StHold,
        StPlay,
        StMatchOver
    } state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [2:0] r_score_l, w_score_l_d;
    logic [2:0] r_score_r, w_score_r_d;
    logic       r_point_l, w_point_l_d;
    logic       r_point_r, w_point_r_d;
    logic       r_win_l, w_win_l_d;
    logic       r_win_r, w_win_r_d;

    logic       w_left_pt;
    logic       w_right_pt;

    // Simultaneous presses cancel: each condition requires the other button idle.
    assign w_left_pt  = ledr9 & L & ~R;
    assign w_right_pt = ledr1 & R & ~L;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_score_l_d = r_score_l;
        w_score_r_d = r_score_r;
        w_point_l_d = 1'b0;
        w_point_r_d = 1'b0;
        w_win_l_d   = r_win_l;
        w_win_r_d   = r_win_r;

        case (r_state)
            StHold: begin
                if (r_cnt == HoldLast) begin
                    w_cnt_d   = 8'd0;
                    w_state_d = StPlay;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StPlay: begin
                if (w_left_pt) begin
                    w_score_l_d = r_score_l + 3'd1;
                    w_point_l_d = 1'b1;
                    if (w_score_l_d == WinVal) begin
                        w_state_d = StMatchOver;
                        w_win_l_d = 1'b1;
                    end else begin
                        w_state_d = StHold;
                        w_cnt_d   = 8'd0;
                    end
                end else if (w_right_pt) begin
                    w_score_r_d = r_score_r + 3'd1;
                    w_point_r_d = 1'b1;
                    if (w_score_r_d == WinVal) begin
                        w_state_d = StMatchOver;
                        w_win_r_d = 1'b1;
                    end else begin
                        w_state_d = StHold;
                        w_cnt_d   = 8'd0;
                    end
                end
            end
            StMatchOver: begin
                if (new_match) begin
                    w_score_l_d = 3'd0;
                    w_score_r_d = 3'd0;
                    w_win_l_d   = 1'b0;
                    w_win_r_d   = 1'b0;
                    w_cnt_d     = 8'd0;
                    w_state_d   = StHold;
                end
            end
            default: begin
                w_state_d = StHold;
                w_cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StHold;
            r_cnt     <= 8'd0;
            r_score_l <= 3'd0;
            r_score_r <= 3'd0;
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            r_win_l   <= 1'b0;
            r_win_r   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_score_l <= w_score_l_d;
            r_score_r <= w_score_r_d;
            r_point_l <= w_point_l_d;
            r_point_r <= w_point_r_d;
            r_win_l   <= w_win_l_d;
            r_win_r   <= w_win_r_d;
        end
    end

    // Decoded from the state register only, so no input reaches an output combinationally.
    assign play_reset = (r_state != StPlay);
    assign match_over = (r_state == StMatchOver);
    assign scoreL     = r_score_l;
    assign scoreR     = r_score_r;
    assign point_L    = r_point_l;
    assign point_R    = r_point_r;
    assign winner_L   = r_win_l;
    assign winner_R   = r_win_r;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized bench for match_ctrl against a score/countdown reference model,
// preceded by a short directed sequence covering reset, ties, winning and new_match.
module tb_match_ctrl;

    localparam int unsigned WIN  = 3;
    localparam int unsigned HOLD = 4;

    logic       clk;
    logic       reset;
    logic       L, R, ledr9, ledr1, new_match;
    logic       play_reset;
    logic [2:0] scoreL, scoreR;
    logic       point_L, point_R, match_over, winner_L, winner_R;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: scores, remaining reset cycles, and match result.
    int m_score_l, m_score_r, m_hold_left;
    bit m_over, m_win_l, m_win_r, m_pt_l, m_pt_r;

    match_ctrl #(
        .WIN_SCORE  (WIN),
        .HOLD_CYCLES(HOLD)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .L         (L),
        .R         (R),
        .ledr9     (ledr9),
        .ledr1     (ledr1),
        .new_match (new_match),
        .play_reset(play_reset),
        .scoreL    (scoreL),
        .scoreR    (scoreR),
        .point_L   (point_L),
        .point_R   (point_R),
        .match_over(match_over),
        .winner_L  (winner_L),
        .winner_R  (winner_R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score_l   = 0;
        m_score_r   = 0;
        m_hold_left = HOLD;
        m_over      = 0;
        m_win_l     = 0;
        m_win_r     = 0;
        m_pt_l      = 0;
        m_pt_r      = 0;
    endtask

    task automatic model_edge();
        bit lp, rp;
        m_pt_l = 0;
        m_pt_r = 0;
        if (m_over) begin
            if (new_match) begin
                m_score_l   = 0;
                m_score_r   = 0;
                m_win_l     = 0;
                m_win_r     = 0;
                m_over      = 0;
                m_hold_left = HOLD;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else begin
            lp = ledr9 && L && !R;
            rp = ledr1 && R && !L;
            if (lp) begin
                m_score_l++;
                m_pt_l = 1;
                if (m_score_l == WIN) begin
                    m_over  = 1;
                    m_win_l = 1;
                end else m_hold_left = HOLD;
            end else if (rp) begin
                m_score_r++;
                m_pt_r = 1;
                if (m_score_r == WIN) begin
                    m_over  = 1;
                    m_win_r = 1;
                end else m_hold_left = HOLD;
            end
        end
    endtask

    task automatic check_all();
        check_val("play_reset", int'(play_reset), int'(m_over || (m_hold_left > 0)));
        check_val("scoreL", int'(scoreL), m_score_l);
        check_val("scoreR", int'(scoreR), m_score_r);
        check_val("point_L", int'(point_L), int'(m_pt_l));
        check_val("point_R", int'(point_R), int'(m_pt_r));
        check_val("match_over", int'(match_over), int'(m_over));
        check_val("winner_L", int'(winner_L), int'(m_win_l));
        check_val("winner_R", int'(winner_R), int'(m_win_r));
    endtask

    // Drive inputs, advance one edge, update the model and compare just after the edge.
    task automatic step(input bit l, input bit r, input bit l9, input bit l1, input bit nm);
        L         = l;
        R         = r;
        ledr9     = l9;
        ledr1     = l1;
        new_match = nm;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Assert reset away from any clock edge; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("async_scoreL", int'(scoreL), 0);
        check_val("async_play_reset", int'(play_reset), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        L         = 1'b0;
        R         = 1'b0;
        ledr9     = 1'b0;
        ledr1     = 1'b0;
        new_match = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset release: HOLD cycles of play_reset, then PLAY.
        for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 0, 0);
        check_val("enter_play", int'(play_reset), 0);

        // Left point, then presses during hold are ignored.
        step(1, 0, 1, 0, 0);
        check_val("first_pt_scoreL", int'(scoreL), 1);
        check_val("first_pt_pulse", int'(point_L), 1);
        step(1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_val("hold_ignores_L", int'(scoreL), 1);

        // Simultaneous presses award nothing.
        step(1, 1, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        check_val("tie_no_point", int'(scoreL) + int'(scoreR), 1);

        // Right wins with three points; scores then stay frozen.
        for (int p = 0; p < int'(WIN); p++) begin
            step(0, 1, 0, 1, 0);
            if (p < int'(WIN) - 1) for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 0, 0);
        end
        check_val("win_scoreR", int'(scoreR), int'(WIN));
        check_val("win_flag_R", int'(winner_R), 1);
        step(0, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        check_val("frozen_scoreR", int'(scoreR), int'(WIN));

        // New match clears and re-enters HOLD.
        step(0, 0, 0, 0, 1);
        check_val("nm_over", int'(match_over), 0);
        for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 0, 0);
        check_val("nm_play", int'(play_reset), 0);

        // Two left points, then reset mid-HOLD.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check_val("pre_reset_scoreL", int'(scoreL), 2);
        #2;
        do_reset();

        // Randomized play with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 15));
            if ($urandom_range(0, 499) == 0) begin
                #($urandom_range(1, 3));
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
